ddr2_cmd_sched: RTL and testbench



---
 rtl/ddr2_cmd_sched.sv | 205 ++++++++++++++++++++
 tb/tb_ddr2_cmd_sched.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_cmd_sched.sv
// Single-rank DDR2 command scheduler: picks one bank request per cycle, enforces t_rrd/t_ccd/t_wtr/t_rtw,
// and drives a registered DFI command. Defining SCHED_PERF_CNT_EN adds saturating performance counters.
module ddr2_cmd_sched #(
    parameter int NUM_BANKS  = 4,
    parameter int RA_WIDTH   = 14,
    parameter int CA_WIDTH   = 10,
    parameter int ADDR_WIDTH = 14,
    parameter int CS_WIDTH   = 1,
    parameter int TW         = 4,
    localparam int BA_WIDTH  = $clog2(NUM_BANKS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [TW-1:0]                 t_rrd,
    input  logic [TW-1:0]                 t_ccd,
    input  logic [TW-1:0]                 t_wtr,
    input  logic [TW-1:0]                 t_rtw,
    input  logic [NUM_BANKS*RA_WIDTH-1:0] ra,
    input  logic [NUM_BANKS*CA_WIDTH-1:0] ca,
    input  logic [NUM_BANKS-1:0]          act_req,
    input  logic [NUM_BANKS-1:0]          rd_req,
    input  logic [NUM_BANKS-1:0]          wr_req,
    input  logic [NUM_BANKS-1:0]          pre_req,
    input  logic [NUM_BANKS-1:0]          ref_req,
    output logic [NUM_BANKS-1:0]          act_gnt,
    output logic [NUM_BANKS-1:0]          rd_gnt,
    output logic [NUM_BANKS-1:0]          wr_gnt,
    output logic [NUM_BANKS-1:0]          pre_gnt,
    output logic [NUM_BANKS-1:0]          ref_gnt,
    output logic                          dfi_cke,
    output logic [CS_WIDTH-1:0]           dfi_cs_n,
    output logic                          dfi_ras_n,
    output logic                          dfi_cas_n,
    output logic                          dfi_we_n,
    output logic [BA_WIDTH-1:0]           dfi_ba,
    output logic [ADDR_WIDTH-1:0]         dfi_addr,
    output logic                          dfi_odt
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_act_cnt,
    output logic [31:0]                   perf_rd_cnt,
    output logic [31:0]                   perf_wr_cnt,
    output logic [31:0]                   perf_stall_cnt
`endif
);

    localparam logic [TW-1:0] T_ONE = TW'(1);

    typedef enum logic [2:0] {C_NOP, C_ACT, C_RD, C_WR, C_PRE, C_REF} cmd_t;

    logic [TW-1:0]         rrd_cnt, ccd_cnt, wtr_cnt, rtw_cnt;
    logic [BA_WIDTH-1:0]   col_ptr, act_ptr, pre_ptr;
    logic                  ref_all, ref_any, rd_ok, wr_ok, act_ok;
    logic [NUM_BANKS-1:0]  col_elig, act_elig;
    cmd_t                  sel_cmd;
    logic [BA_WIDTH-1:0]   sel_bank;
    logic [2:0]            nxt_cmd;
    logic [BA_WIDTH-1:0]   nxt_ba;
    logic [ADDR_WIDTH-1:0] nxt_addr;

    // first requester at or after ptr, wrapping
    function automatic logic [BA_WIDTH-1:0] rr_pick(input logic [NUM_BANKS-1:0] req,
                                                    input logic [BA_WIDTH-1:0] ptr);
        logic [BA_WIDTH-1:0] pick;
        pick = ptr;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NUM_BANKS]) pick = BA_WIDTH'((int'(ptr) + i) % NUM_BANKS);
        end
        return pick;
    endfunction

    function automatic logic [BA_WIDTH-1:0] ptr_after(input logic [BA_WIDTH-1:0] b);
        return BA_WIDTH'((int'(b) + 1) % NUM_BANKS);
    endfunction

    function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] v);
        return (v == '0) ? '0 : v - T_ONE;
    endfunction

    always_comb begin
        ref_all  = &ref_req;
        ref_any  = |ref_req;
        rd_ok    = (ccd_cnt == '0) && (wtr_cnt == '0);
        wr_ok    = (ccd_cnt == '0) && (rtw_cnt == '0);
        act_ok   = (rrd_cnt == '0) && !ref_any;
        act_elig = act_ok ? act_req : '0;
        col_elig = '0;
        // a bank raising both rd and wr is treated as a read
        for (int b = 0; b < NUM_BANKS; b++) begin
            col_elig[b] = rd_req[b] ? rd_ok : (wr_req[b] && wr_ok);
        end
    end

    always_comb begin
        act_gnt  = '0;
        rd_gnt   = '0;
        wr_gnt   = '0;
        pre_gnt  = '0;
        ref_gnt  = '0;
        sel_cmd  = C_NOP;
        sel_bank = '0;
        if (rst_n) begin
            if (ref_all) begin
                ref_gnt = '1;
                sel_cmd = C_REF;
            end else if (|col_elig) begin
                sel_bank = rr_pick(col_elig, col_ptr);
                if (rd_req[sel_bank]) begin
                    rd_gnt[sel_bank] = 1'b1;
                    sel_cmd          = C_RD;
                end else begin
                    wr_gnt[sel_bank] = 1'b1;
                    sel_cmd          = C_WR;
                end
            end else if (|act_elig) begin
                sel_bank          = rr_pick(act_elig, act_ptr);
                act_gnt[sel_bank] = 1'b1;
                sel_cmd           = C_ACT;
            end else if (|pre_req) begin
                sel_bank          = rr_pick(pre_req, pre_ptr);
                pre_gnt[sel_bank] = 1'b1;
                sel_cmd           = C_PRE;
            end
        end
    end

    always_comb begin
        nxt_cmd  = 3'b111;
        nxt_ba   = sel_bank;
        nxt_addr = '0;
        case (sel_cmd)
            C_ACT: begin
                nxt_cmd  = 3'b011;
                nxt_addr = ADDR_WIDTH'(ra[int'(sel_bank) * RA_WIDTH +: RA_WIDTH]);
            end
            C_RD, C_WR: begin
                nxt_cmd      = (sel_cmd == C_RD) ? 3'b101 : 3'b100;
                nxt_addr     = ADDR_WIDTH'(ca[int'(sel_bank) * CA_WIDTH +: CA_WIDTH]);
                nxt_addr[10] = 1'b0;
            end
            C_PRE:   nxt_cmd = 3'b010;
            C_REF: begin
                nxt_cmd = 3'b001;
                nxt_ba  = '0;
            end
            default: nxt_ba = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dfi_cke   <= 1'b0;
            dfi_cs_n  <= '1;
            dfi_ras_n <= 1'b1;
            dfi_cas_n <= 1'b1;
            dfi_we_n  <= 1'b1;
            dfi_ba    <= '0;
            dfi_addr  <= '0;
            dfi_odt   <= 1'b0;
            rrd_cnt   <= '0;
            ccd_cnt   <= '0;
            wtr_cnt   <= '0;
            rtw_cnt   <= '0;
            col_ptr   <= '0;
            act_ptr   <= '0;
            pre_ptr   <= '0;
        end else begin
            dfi_cke                          <= 1'b1;
            dfi_cs_n                         <= '0;
            {dfi_ras_n, dfi_cas_n, dfi_we_n} <= nxt_cmd;
            dfi_ba                           <= nxt_ba;
            dfi_addr                         <= nxt_addr;
            dfi_odt                          <= (sel_cmd == C_WR);
            // REF deliberately leaves every inter-bank timer untouched
            rrd_cnt <= (sel_cmd == C_ACT) ? dec_sat(t_rrd) : dec_sat(rrd_cnt);
            ccd_cnt <= (sel_cmd == C_RD || sel_cmd == C_WR) ? dec_sat(t_ccd) : dec_sat(ccd_cnt);
            wtr_cnt <= (sel_cmd == C_WR) ? dec_sat(t_wtr) : dec_sat(wtr_cnt);
            rtw_cnt <= (sel_cmd == C_RD) ? dec_sat(t_rtw) : dec_sat(rtw_cnt);
            if (sel_cmd == C_RD || sel_cmd == C_WR) col_ptr <= ptr_after(sel_bank);
            if (sel_cmd == C_ACT) act_ptr <= ptr_after(sel_bank);
            if (sel_cmd == C_PRE) pre_ptr <= ptr_after(sel_bank);
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic req_pending;
    assign req_pending = |{act_req, rd_req, wr_req, pre_req, ref_req};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_act_cnt   <= '0;
            perf_rd_cnt    <= '0;
            perf_wr_cnt    <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (sel_cmd == C_ACT && perf_act_cnt != '1) perf_act_cnt <= perf_act_cnt + 32'd1;
            if (sel_cmd == C_RD && perf_rd_cnt != '1) perf_rd_cnt <= perf_rd_cnt + 32'd1;
            if (sel_cmd == C_WR && perf_wr_cnt != '1) perf_wr_cnt <= perf_wr_cnt + 32'd1;
            if (req_pending && sel_cmd == C_NOP && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ddr2_cmd_sched.sv
// Scoreboard bench for ddr2_cmd_sched: scenarios push expected grants (kind, bank, cycle);
// a negedge monitor pops them on each grant and checks the DFI bus one cycle later.
module tb_ddr2_cmd_sched;

    localparam int K_ACT = 0, K_RD = 1, K_WR = 2, K_PRE = 3, K_REF = 4, K_NOP = 5;

    typedef struct {
        int kind;
        int bank;
        int cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  t_rrd, t_ccd, t_wtr, t_rtw;
    logic [55:0] ra;
    logic [39:0] ca;
    logic [3:0]  act_req, rd_req, wr_req, pre_req, ref_req;
    logic [3:0]  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic        dfi_cke;
    logic [0:0]  dfi_cs_n;
    logic        dfi_ras_n, dfi_cas_n, dfi_we_n;
    logic [1:0]  dfi_ba;
    logic [13:0] dfi_addr;
    logic        dfi_odt;

    logic [13:0] ra_b [4];
    logic [9:0]  ca_b [4];

    int   total = 0;
    int   bad = 0;
    int   cyc_n = 0;
    exp_t exp_q[$];
    logic auto_drop = 1'b1;
    logic [3:0] last_act = '0, last_rd = '0, last_wr = '0, last_pre = '0, last_ref = '0;

    // monitor state
    logic        prev_rst = 1'b0;
    int          exp_kind = K_NOP;
    logic [5:0]  exp_ctl = 6'b101110;
    logic [15:0] exp_ba_addr = '0;
    logic [19:0] all_gnt;
    int          g_kind, g_bank;
    exp_t        e;

    assign ra = {ra_b[3], ra_b[2], ra_b[1], ra_b[0]};
    assign ca = {ca_b[3], ca_b[2], ca_b[1], ca_b[0]};

    always #5 clk = ~clk;

    ddr2_cmd_sched dut (
        .clk(clk), .rst_n(rst_n),
        .t_rrd(t_rrd), .t_ccd(t_ccd), .t_wtr(t_wtr), .t_rtw(t_rtw),
        .ra(ra), .ca(ca),
        .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req), .ref_req(ref_req),
        .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
        .dfi_cke(dfi_cke), .dfi_cs_n(dfi_cs_n), .dfi_ras_n(dfi_ras_n), .dfi_cas_n(dfi_cas_n),
        .dfi_we_n(dfi_we_n), .dfi_ba(dfi_ba), .dfi_addr(dfi_addr), .dfi_odt(dfi_odt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int kind, input int bank, input int cyc);
        exp_t x;
        x.kind = kind;
        x.bank = bank;
        x.cyc  = cyc;
        exp_q.push_back(x);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check_val("drain", exp_q.size(), 0);
    endtask

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // banks release a request the cycle after it is granted
    always @(posedge clk) begin
        #1;
        if (auto_drop) begin
            act_req = act_req & ~last_act;
            rd_req  = rd_req & ~last_rd;
            wr_req  = wr_req & ~last_wr;
            pre_req = pre_req & ~last_pre;
            ref_req = ref_req & ~last_ref;
        end
    end

    always @(negedge clk) begin
        if (cyc_n > 0) begin
            if (!prev_rst) begin
                check_val("bus_in_reset", {dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_odt,
                                           dfi_ba, dfi_addr}, {6'b011110, 16'h0000});
            end else begin
                check_val("bus_ctl", {dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_odt}, exp_ctl);
                if (exp_kind == K_PRE)
                    check_val("bus_pre_ba_a10", {dfi_ba, dfi_addr[10]}, {exp_ba_addr[15:14], 1'b0});
                else if (exp_kind != K_NOP)
                    check_val("bus_ba_addr", {dfi_ba, dfi_addr}, exp_ba_addr);
            end

            all_gnt     = {ref_gnt, pre_gnt, wr_gnt, rd_gnt, act_gnt};
            last_act    = rst_n ? act_gnt : '0;
            last_rd     = rst_n ? rd_gnt : '0;
            last_wr     = rst_n ? wr_gnt : '0;
            last_pre    = rst_n ? pre_gnt : '0;
            last_ref    = rst_n ? ref_gnt : '0;
            exp_kind    = K_NOP;
            exp_ctl     = 6'b101110;
            exp_ba_addr = '0;

            if (!rst_n) begin
                check_val("gnt_in_reset", all_gnt, 0);
            end else if (all_gnt != '0) begin
                g_kind = K_NOP;
                g_bank = 0;
                if (ref_gnt != '0) begin
                    g_kind = K_REF;
                    check_val("ref_gnt_all", all_gnt, {4'hF, 16'h0000});
                end else begin
                    check_val("gnt_onehot", $countones(all_gnt), 1);
                    for (int i = 15; i >= 0; i--) begin
                        if (all_gnt[i]) begin
                            g_kind = i / 4;
                            g_bank = i % 4;
                        end
                    end
                end
                if (exp_q.size() == 0) begin
                    check_val("unexpected_gnt", all_gnt, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("gnt_kind", g_kind, e.kind);
                    check_val("gnt_bank", g_bank, e.bank);
                    check_val("gnt_cycle", cyc_n, e.cyc);
                    exp_kind = e.kind;
                    case (e.kind)
                        K_ACT: begin exp_ctl = 6'b100110; exp_ba_addr = {2'(e.bank), ra_b[e.bank]}; end
                        K_RD:  begin exp_ctl = 6'b101010; exp_ba_addr = {2'(e.bank), 4'h0, ca_b[e.bank]}; end
                        K_WR:  begin exp_ctl = 6'b101001; exp_ba_addr = {2'(e.bank), 4'h0, ca_b[e.bank]}; end
                        K_PRE: begin exp_ctl = 6'b100100; exp_ba_addr = {2'(e.bank), 14'h0}; end
                        default: begin exp_ctl = 6'b100010; exp_ba_addr = '0; end
                    endcase
                end
            end
            prev_rst = rst_n;
        end
    end

    initial begin
        ra_b[0] = 14'h2A5C; ra_b[1] = 14'h1357; ra_b[2] = 14'h3FFF; ra_b[3] = 14'h0F0F;
        ca_b[0] = 10'h3A5;  ca_b[1] = 10'h0C3;  ca_b[2] = 10'h2F0;  ca_b[3] = 10'h111;
        rst_n = 1'b0;
        t_rrd = 4'd1; t_ccd = 4'd1; t_wtr = 4'd1; t_rtw = 4'd1;
        act_req = 4'b1111; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
        repeat (3) tick();
        act_req = '0;
        rst_n = 1'b1;
        repeat (4) tick();

        // ACT spacing by t_rrd
        t_rrd = 4'd4;
        act_req = 4'b0101;
        push(K_ACT, 0, cyc_n);
        push(K_ACT, 2, cyc_n + 4);
        drain(30);
        repeat (16) tick();

        // WR then RD on bank1: t_wtr dominates t_ccd
        t_wtr = 4'd3; t_ccd = 4'd2;
        wr_req = 4'b0010;
        push(K_WR, 1, cyc_n);
        tick();
        rd_req = 4'b0010;
        push(K_RD, 1, cyc_n + 2);
        drain(30);
        repeat (16) tick();

        // column round-robin with all banks holding reads
        t_wtr = 4'd1; t_ccd = 4'd1;
        rd_req = 4'b0001;
        push(K_RD, 0, cyc_n);
        tick();
        auto_drop = 1'b0;
        rd_req = 4'b1111;
        push(K_RD, 1, cyc_n);
        push(K_RD, 2, cyc_n + 1);
        push(K_RD, 3, cyc_n + 2);
        push(K_RD, 0, cyc_n + 3);
        repeat (4) tick();
        rd_req = '0;
        auto_drop = 1'b1;
        drain(5);
        repeat (16) tick();

        // partial refresh blocks ACT; full refresh wins, then ACT proceeds
        t_rrd = 4'd1;
        ref_req = 4'b0111;
        act_req = 4'b1000;
        repeat (5) begin
            @(negedge clk);
            check_val("ref_drain_block", {act_gnt, ref_gnt}, 0);
            tick();
        end
        ref_req = 4'b1111;
        push(K_REF, 0, cyc_n);
        push(K_ACT, 3, cyc_n + 1);
        drain(30);
        repeat (16) tick();

        // PRE round-robin, then class priority RD > ACT > PRE
        pre_req = 4'b0110;
        push(K_PRE, 1, cyc_n);
        push(K_PRE, 2, cyc_n + 1);
        drain(30);
        repeat (4) tick();
        rd_req = 4'b0001; act_req = 4'b0010; pre_req = 4'b1000;
        push(K_RD, 0, cyc_n);
        push(K_ACT, 1, cyc_n + 1);
        push(K_PRE, 3, cyc_n + 2);
        drain(30);
        repeat (16) tick();

        // t_rrd=0 allows back-to-back ACT
        t_rrd = 4'd0;
        act_req = 4'b0011;
        push(K_ACT, 0, cyc_n);
        push(K_ACT, 1, cyc_n + 1);
        drain(30);
        repeat (16) tick();

        // rd and wr on one bank: read first, write after t_rtw
        t_rtw = 4'd3;
        rd_req = 4'b0100; wr_req = 4'b0100;
        push(K_RD, 2, cyc_n);
        push(K_WR, 2, cyc_n + 3);
        drain(30);
        repeat (16) tick();

        // reset mid-operation clears the read-to-write timer
        t_rtw = 4'd6; t_ccd = 4'd4;
        rd_req = 4'b0001;
        push(K_RD, 0, cyc_n);
        tick();
        check_val("rtw_loaded", dut.rtw_cnt, 5);
        rst_n = 1'b0;
        tick();
        check_val("rtw_after_reset", dut.rtw_cnt, 0);
        rst_n = 1'b1;
        wr_req = 4'b0001;
        push(K_WR, 0, cyc_n);
        drain(10);
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog");
    end

endmodule
